// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, debounces a
// press and its release over DEB_SCANS scan ticks, and reports the accepted key
// code with a pending flag, a held flag and a sticky overrun flag.
module keypad_scan #(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] io_keypad_row,
  output logic [3:0] io_keypad_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_pressed,
  output logic       overrun
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SCANS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HOLD, S_RELEASE} state_t;

  state_t          state;
  logic [1:0][3:0] sync_pipe;
  logic [3:0]      rows;
  logic [DW-1:0]   div;
  logic            tick;
  logic [1:0]      col_idx;
  logic [1:0]      row_idx;
  logic [CW-1:0]   deb_cnt;
  logic [CW-1:0]   rel_cnt;
  logic            any_low;
  logic [1:0]      low_idx;
  logic            cap_low;
  logic            accept;
  logic [3:0]      acc_code;

  // two-flop synchronizer for the asynchronous row lines; idles at "no key"
  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '1;
    else     sync_pipe <= {sync_pipe[0], io_keypad_row};
  end

  assign rows = sync_pipe[1];

  // free-running dwell divider; tick marks the last cycle of each dwell
  always_ff @(posedge clk) begin
    if (rst)       div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  assign tick = (div == DIV_LAST);

  // column strobe follows the column index directly
  assign io_keypad_col = ~(4'b0001 << col_idx);

  // lowest-numbered low row wins when several rows are pulled down
  always_comb begin
    any_low = ~&rows;
    low_idx = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!rows[r]) low_idx = 2'(r);
    end
  end

  assign cap_low = ~rows[row_idx];

  // accept fires on the tick that completes the press streak
  always_comb begin
    accept   = 1'b0;
    acc_code = {row_idx, col_idx};
    if (tick) begin
      if (state == S_SCAN && any_low && DEB_SCANS == 1) begin
        accept   = 1'b1;
        acc_code = {low_idx, col_idx};
      end else if (state == S_DEBOUNCE && cap_low && deb_cnt == CNT_LAST) begin
        accept = 1'b1;
      end
    end
  end

  // scan / debounce / hold / release sequencing, advancing only on tick
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_SCAN;
      col_idx     <= '0;
      row_idx     <= '0;
      deb_cnt     <= '0;
      rel_cnt     <= '0;
      key_pressed <= 1'b0;
    end else if (tick) begin
      case (state)
        S_SCAN: begin
          if (!any_low) begin
            col_idx <= col_idx + 2'd1;
          end else begin
            row_idx <= low_idx;
            deb_cnt <= CNT_ONE;
            if (accept) begin
              state       <= S_HOLD;
              key_pressed <= 1'b1;
            end else begin
              state <= S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (!cap_low) begin
            state   <= S_SCAN;
            col_idx <= col_idx + 2'd1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
            if (accept) begin
              state       <= S_HOLD;
              key_pressed <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // only the captured row matters here; other keys are ignored
          if (!cap_low) begin
            rel_cnt <= CNT_ONE;
            if (DEB_SCANS == 1) begin
              state       <= S_SCAN;
              col_idx     <= col_idx + 2'd1;
              key_pressed <= 1'b0;
            end else begin
              state <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (cap_low) begin
            state <= S_HOLD;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
            if (rel_cnt == CNT_LAST) begin
              state       <= S_SCAN;
              col_idx     <= col_idx + 2'd1;
              key_pressed <= 1'b0;
            end
          end
        end
        default: begin
          state       <= S_SCAN;
          key_pressed <= 1'b0;
        end
      endcase
    end
  end

  // key mailbox: a new accept beats a simultaneous ack; an unread key being
  // overwritten without an ack raises the sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (accept) begin
      key_code  <= acc_code;
      key_valid <= 1'b1;
      if (key_valid && !key_ack) overrun <= 1'b1;
      else if (key_ack)          overrun <= 1'b0;
    end else if (key_ack && key_valid) begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule
